// File: rtl/spi_fetch.sv
// spi_fetch: responder side of the control unit's instruction-fetch handshake.
// On a fetch request the block latches pc and runs one SPI flash READ
// transaction (mode 0, SCLK = clk/2). It returns the fetched byte on data and
// acknowledges with a 4-phase request/acknowledge handshake on spi_done.
//
// Parameters:
//   READ_CMD      command byte shifted out first
//   ADDR_HI       upper byte of the 24-bit flash address
// Ports:
//   clk           system clock, all state updates on posedge
//   rst           asynchronous active-high reset
//   spi_executing fetch request from the control unit (level)
//   pc            16-bit byte address, sampled on request acceptance
//   spi_done      acknowledge; data valid while high
//   data          fetched byte, held until the next capture
//   busy          high from acceptance until spi_done rises
//   sclk          SPI clock, idles low
//   cs_n          flash chip select, active low
//   mosi          serial data to flash
//   miso          serial data from flash
module spi_fetch #(
  parameter logic [7:0] READ_CMD = 8'h03,
  parameter logic [7:0] ADDR_HI  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_executing,
  input  logic [15:0] pc,
  output logic        spi_done,
  output logic [7:0]  data,
  output logic        busy,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      r_state;
  // Command, address and eight trailing zeros: the zeros drive mosi low
  // during the data-receive periods without extra muxing.
  logic [39:0] r_shift;
  logic [5:0]  r_bitcnt;
  logic        r_phase_b;
  logic [6:0]  r_rx;
  logic [7:0]  r_data;
  logic        r_sclk;
  logic        r_cs_n;
  logic        r_busy;
  logic        r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_phase_b <= 1'b0;
      r_rx      <= '0;
      r_data    <= '0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sclk <= 1'b0;
          r_cs_n <= 1'b1;
          r_busy <= 1'b0;
          if (spi_executing) begin
            r_shift   <= {READ_CMD, ADDR_HI, pc, 8'h00};
            r_bitcnt  <= '0;
            r_phase_b <= 1'b0;
            r_cs_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!r_phase_b) begin
            r_sclk    <= 1'b1;
            r_phase_b <= 1'b1;
          end else begin
            // End of a bit period: sample miso, drop sclk, present next bit.
            r_phase_b <= 1'b0;
            r_sclk    <= 1'b0;
            r_rx      <= {r_rx[5:0], miso};
            r_shift   <= {r_shift[38:0], 1'b0};
            if (r_bitcnt == 6'd39) begin
              r_data  <= {r_rx, miso};
              r_cs_n  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_bitcnt <= r_bitcnt + 6'd1;
            end
          end
        end
        S_DONE: begin
          if (!spi_executing) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spi_done = r_done;
  assign data     = r_data;
  assign busy     = r_busy;
  assign sclk     = r_sclk;
  assign cs_n     = r_cs_n;
  assign mosi     = r_shift[39];

endmodule

// File: tb/tb_spi_fetch.sv
module tb_spi_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_executing;
  logic [15:0] pc;
  logic        spi_done;
  logic [7:0]  data;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_fetch #(.READ_CMD(8'h03), .ADDR_HI(8'h00)) dut (
    .clk(clk), .rst(rst), .spi_executing(spi_executing), .pc(pc),
    .spi_done(spi_done), .data(data), .busy(busy), .sclk(sclk),
    .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  // Scoreboard: expected address and byte per request, oldest first.
  typedef struct {
    logic [15:0] pc;
    logic [7:0]  data;
  } exp_t;
  exp_t exp_q[$];

  // Flash model: captures mosi on sclk rise, shifts out the response byte
  // on sclk fall after the 32 command/address bits.
  logic [39:0] f_rx;
  int          f_rises = 0;
  logic [7:0]  f_resp;
  int          cs_falls = 0;
  int          hi_cnt = 0;
  int          last_hi = 0;

  always @(negedge cs_n) begin
    cs_falls++;
    f_rises = 0;
    f_rx    = '0;
    f_resp  = (exp_q.size() > 0) ? exp_q[0].data : 8'h00;
    miso    = 1'b0;
  end

  always @(posedge sclk) begin
    if (cs_n === 1'b0) begin
      f_rx = {f_rx[38:0], mosi};
      f_rises++;
    end
  end

  always @(negedge sclk) begin
    if (cs_n === 1'b0 && f_rises >= 32 && f_rises < 40)
      miso = f_resp[39 - f_rises];
  end

  always @(negedge clk) begin
    if (cs_n === 1'b1) hi_cnt++;
    else if (hi_cnt > 0) begin
      last_hi = hi_cnt;
      hi_cnt  = 0;
    end
  end

  task automatic fetch(input logic [15:0] p, input logic [7:0] d, input int hold,
                       input int drop_at, input logic [15:0] pc_alt);
    int   n;
    logic got;
    logic bad;
    int   falls0;
    exp_t e;
    @(negedge clk);
    pc = p;
    spi_executing = 1'b1;
    exp_q.push_back('{p, d});
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || cs_n !== 1'b0) begin
      errors++;
      $display("FAIL accept pc=%h busy=%b cs_n=%b expected busy=1 cs_n=0", p, busy, cs_n);
    end
    n = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      @(negedge clk);
      if (drop_at > 0 && n == drop_at) begin
        spi_executing = 1'b0;
        pc = pc_alt;
      end
      @(posedge clk); #1;
      n++;
      if (spi_done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout pc=%h spi_done=%b after %0d cycles expected 1", p, spi_done, n);
    end
    checks++;
    if (n !== 80) begin
      errors++;
      $display("FAIL latency pc=%h got %0d expected 80", p, n);
    end
    e = exp_q.pop_front();
    checks++;
    if (data !== e.data) begin
      errors++;
      $display("FAIL data pc=%h got %h expected %h", p, data, e.data);
    end
    checks++;
    if (f_rises !== 40) begin
      errors++;
      $display("FAIL sclk_rises pc=%h got %0d expected 40", p, f_rises);
    end
    checks++;
    if (f_rx !== {8'h03, 8'h00, e.pc, 8'h00}) begin
      errors++;
      $display("FAIL mosi_stream got %h expected %h", f_rx, {8'h03, 8'h00, e.pc, 8'h00});
    end
    checks++;
    if (busy !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL end_pins busy=%b cs_n=%b sclk=%b expected 0 1 0", busy, cs_n, sclk);
    end
    if (drop_at > 0) begin
      @(posedge clk); #1;
      checks++;
      if (spi_done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse spi_done=%b one cycle later expected 0", spi_done);
      end
    end else begin
      falls0 = cs_falls;
      bad = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (spi_done !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL done_held spi_done dropped while request high, expected 1");
      end
      checks++;
      if (cs_falls !== falls0) begin
        errors++;
        $display("FAIL no_refetch cs_n falls got %0d expected %0d", cs_falls, falls0);
      end
      checks++;
      if (data !== e.data) begin
        errors++;
        $display("FAIL data_held got %h expected %h", data, e.data);
      end
      @(negedge clk);
      spi_executing = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (spi_done !== 1'b0) begin
        errors++;
        $display("FAIL done_release spi_done=%b expected 0", spi_done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cs_n, sclk, mosi, spi_done, busy} !== 5'b10000 || data !== 8'h00) begin
      errors++;
      $display("FAIL reset cs_n,sclk,mosi,done,busy=%b%b%b%b%b data=%h expected 10000 data=00",
               cs_n, sclk, mosi, spi_done, busy, data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    fetch(16'h1234, 8'hA5, 0, 0, 16'h0000);
  endtask

  task automatic test_held_request();
    fetch(16'h5678, 8'h69, 20, 0, 16'h0000);
  endtask

  task automatic test_back_to_back();
    fetch(16'hFFFF, 8'h3C, 0, 0, 16'h0000);
    fetch(16'h0000, 8'hC3, 0, 0, 16'h0000);
    checks++;
    if (last_hi < 2) begin
      errors++;
      $display("FAIL cs_high_time got %0d cycles expected >=2", last_hi);
    end
  endtask

  task automatic test_drop_pc_change();
    fetch(16'hBEEF, 8'h96, 0, 10, 16'h1357);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    pc = 16'h1111;
    spi_executing = 1'b1;
    exp_q.push_back('{16'h1111, 8'h77});
    @(posedge clk);
    repeat (50) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || spi_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset cs_n=%b sclk=%b busy=%b done=%b expected 1 0 0 0",
               cs_n, sclk, busy, spi_done);
    end
    void'(exp_q.pop_front());
    spi_executing = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fetch(16'h0042, 8'h5A, 0, 0, 16'h0000);
  endtask

  initial begin
    rst = 1'b1;
    spi_executing = 1'b0;
    pc = 16'h0000;
    miso = 1'b0;
    test_reset();
    test_basic_fetch();
    test_held_request();
    test_back_to_back();
    test_drop_pc_change();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
